udma_eth_rx_frame_meter: RTL

Parametrised AXI-stream frame meter for the uDMA Ethernet receive path, running entirely in the 125 MHz Ethernet domain. It passively monitors the MAC-to-buffer AXI-stream handshake, measures each frame's byte length across multi-byte beats, and classifies the frame as good, bad, runt or oversize. It emits one length/status descriptor per frame on a valid/ready port, normally feeding the dual-clock packet queue toward the system-clock receive controller. It also keeps saturating statistics and raises single-cycle error and overflow events.

---
 rtl/udma_eth_rx_frame_meter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/udma_eth_rx_frame_meter.sv
// Passive AXI-stream frame meter: per-frame length/status descriptor plus saturating stats.
// Latency: descriptor, events and counters update the cycle after the tlast beat.
// Backpressure: one-deep descriptor register; a descriptor that cannot load is counted as overflow.
module udma_eth_rx_frame_meter #(
    parameter int DATA_BYTES = 1,
    parameter int LEN_WIDTH  = 11,
    parameter int MIN_LEN    = 64,
    parameter int MAX_LEN    = 1518,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  eth_clk_i,
    input  logic                  eth_rstn_i,
    input  logic                  s_axis_tvalid_i,
    input  logic                  s_axis_tready_i,
    input  logic                  s_axis_tlast_i,
    input  logic [DATA_BYTES-1:0] s_axis_tkeep_i,
    input  logic                  s_axis_tuser_i,
    input  logic                  cfg_drop_err_i,
    input  logic                  stat_clr_i,
    output logic                  desc_valid_o,
    input  logic                  desc_ready_i,
    output logic [LEN_WIDTH-1:0]  desc_len_o,
    output logic [2:0]            desc_status_o,
    output logic [CNT_WIDTH-1:0]  stat_frames_o,
    output logic [CNT_WIDTH-1:0]  stat_errors_o,
    output logic [CNT_WIDTH-1:0]  stat_overflow_o,
    output logic                  error_event_o,
    output logic                  overflow_event_o
);

    localparam logic [LEN_WIDTH-1:0] MIN_L   = LEN_WIDTH'(MIN_LEN);
    localparam logic [LEN_WIDTH-1:0] MAX_L   = LEN_WIDTH'(MAX_LEN);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic {
        ST_IDLE,
        ST_FRAME
    } state_t;

    state_t               state_q;
    logic [LEN_WIDTH-1:0] acc_q;
    logic                 bad_q;

    logic                 beat;
    logic                 done;
    logic [LEN_WIDTH:0]   beat_bytes;
    logic [LEN_WIDTH:0]   sum;
    logic [LEN_WIDTH-1:0] len_sat;
    logic                 bad_all;
    logic [2:0]           status;
    logic                 errored;
    logic                 gen;
    logic                 load;
    logic                 lost;

    // Byte count of the current beat: popcount of the byte enables.
    always_comb begin
        beat_bytes = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            beat_bytes = beat_bytes + {{LEN_WIDTH{1'b0}}, s_axis_tkeep_i[i]};
        end
    end

    assign beat    = s_axis_tvalid_i & s_axis_tready_i;
    assign done    = beat & s_axis_tlast_i;
    // Extra carry bit catches wrap; the length pins at all-ones instead.
    assign sum     = {1'b0, acc_q} + beat_bytes;
    assign len_sat = sum[LEN_WIDTH] ? '1 : sum[LEN_WIDTH-1:0];
    assign bad_all = bad_q | s_axis_tuser_i;
    assign status  = {len_sat > MAX_L, len_sat < MIN_L, bad_all};
    assign errored = |status;
    assign gen     = done & ~(cfg_drop_err_i & errored);
    assign load    = gen & (~desc_valid_o | desc_ready_i);
    assign lost    = gen & desc_valid_o & ~desc_ready_i;

    // Frame tracking FSM: accumulates length and bad flag until the last beat.
    always_ff @(posedge eth_clk_i or negedge eth_rstn_i) begin
        if (!eth_rstn_i) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            bad_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // A single-beat frame completes here and leaves acc at zero.
                    if (beat && !s_axis_tlast_i) begin
                        state_q <= ST_FRAME;
                        acc_q   <= len_sat;
                        bad_q   <= bad_all;
                    end
                end
                ST_FRAME: begin
                    if (beat) begin
                        if (s_axis_tlast_i) begin
                            state_q <= ST_IDLE;
                            acc_q   <= '0;
                            bad_q   <= 1'b0;
                        end else begin
                            acc_q   <= len_sat;
                            bad_q   <= bad_all;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    acc_q   <= '0;
                    bad_q   <= 1'b0;
                end
            endcase
        end
    end

    // One-deep descriptor register; a new descriptor can replace one being consumed.
    always_ff @(posedge eth_clk_i or negedge eth_rstn_i) begin
        if (!eth_rstn_i) begin
            desc_valid_o  <= 1'b0;
            desc_len_o    <= '0;
            desc_status_o <= '0;
        end else if (load) begin
            desc_valid_o  <= 1'b1;
            desc_len_o    <= len_sat;
            desc_status_o <= status;
        end else if (desc_valid_o && desc_ready_i) begin
            desc_valid_o  <= 1'b0;
        end
    end

    // Single-cycle event pulses, independent of statistics clear.
    always_ff @(posedge eth_clk_i or negedge eth_rstn_i) begin
        if (!eth_rstn_i) begin
            error_event_o    <= 1'b0;
            overflow_event_o <= 1'b0;
        end else begin
            error_event_o    <= done & errored;
            overflow_event_o <= lost;
        end
    end

    // Saturating statistics; clear takes priority over any increment.
    always_ff @(posedge eth_clk_i or negedge eth_rstn_i) begin
        if (!eth_rstn_i) begin
            stat_frames_o   <= '0;
            stat_errors_o   <= '0;
            stat_overflow_o <= '0;
        end else if (stat_clr_i) begin
            stat_frames_o   <= '0;
            stat_errors_o   <= '0;
            stat_overflow_o <= '0;
        end else begin
            if (done && stat_frames_o != CNT_MAX) begin
                stat_frames_o <= stat_frames_o + 1'b1;
            end
            if (done && errored && stat_errors_o != CNT_MAX) begin
                stat_errors_o <= stat_errors_o + 1'b1;
            end
            if (lost && stat_overflow_o != CNT_MAX) begin
                stat_overflow_o <= stat_overflow_o + 1'b1;
            end
        end
    end

endmodule
